// File: rtl/median3x3_sched.sv
// 3x3 median scheduler: issues 7 ops to one shared registered sort3 and returns the median.
// Optional border pass-through (centre pixel, no sorter ops): define MEDIAN_BORDER_BYPASS_EN.
module median3x3_sched #(
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9*DW-1:0]   win_data,
    output logic [DW-1:0]     srt_d1,
    output logic [DW-1:0]     srt_d2,
    output logic [DW-1:0]     srt_d3,
    input  logic [DW-1:0]     srt_max,
    input  logic [DW-1:0]     srt_mid,
    input  logic [DW-1:0]     srt_min,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     median
`ifdef MEDIAN_BORDER_BYPASS_EN
    ,
    input  logic              in_border
`endif
);

    localparam int unsigned NPIX = 9;
    localparam int unsigned NROW = 3;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_R0   = 4'd1,
        S_R1   = 4'd2,
        S_R2   = 4'd3,
        S_W1   = 4'd4,
        S_C0   = 4'd5,
        S_C1   = 4'd6,
        S_C2   = 4'd7,
        S_W2   = 4'd8,
        S_F    = 4'd9,
        S_W3   = 4'd10,
        S_DONE = 4'd11,
        S_BYP  = 4'd12
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [DW-1:0]  r_p   [NPIX];
    logic [DW-1:0]  r_max [NROW];
    logic [DW-1:0]  r_mid [NROW];
    logic [DW-1:0]  r_min [NROW];
    logic [DW-1:0]  r_c0;
    logic [DW-1:0]  r_c1;
    logic [DW-1:0]  r_c2;
    logic [DW-1:0]  r_median;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_release;

    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid & in_ready;
    assign w_release = r_out_valid & out_ready;
    assign out_valid = r_out_valid;
    assign median    = r_median;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: fixed one-cycle-per-state walk; unknown encodings fall back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef MEDIAN_BORDER_BYPASS_EN
                    w_state_nxt = in_border ? S_BYP : S_R0;
`else
                    w_state_nxt = S_R0;
`endif
                end
            end
            S_R0:   w_state_nxt = S_R1;
            S_R1:   w_state_nxt = S_R2;
            S_R2:   w_state_nxt = S_W1;
            S_W1:   w_state_nxt = S_C0;
            S_C0:   w_state_nxt = S_C1;
            S_C1:   w_state_nxt = S_C2;
            S_C2:   w_state_nxt = S_W2;
            S_W2:   w_state_nxt = S_F;
            S_F:    w_state_nxt = S_W3;
            S_W3:   w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef MEDIAN_BORDER_BYPASS_EN
            S_BYP:  w_state_nxt = S_DONE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sorter operand decode; idle/wait states drive zeros
    always_comb begin
        srt_d1 = '0;
        srt_d2 = '0;
        srt_d3 = '0;
        case (r_state)
            S_R0: begin
                srt_d1 = r_p[0];
                srt_d2 = r_p[1];
                srt_d3 = r_p[2];
            end
            S_R1: begin
                srt_d1 = r_p[3];
                srt_d2 = r_p[4];
                srt_d3 = r_p[5];
            end
            S_R2: begin
                srt_d1 = r_p[6];
                srt_d2 = r_p[7];
                srt_d3 = r_p[8];
            end
            S_C0: begin
                srt_d1 = r_min[0];
                srt_d2 = r_min[1];
                srt_d3 = r_min[2];
            end
            S_C1: begin
                srt_d1 = r_mid[0];
                srt_d2 = r_mid[1];
                srt_d3 = r_mid[2];
            end
            S_C2: begin
                srt_d1 = r_max[0];
                srt_d2 = r_max[1];
                srt_d3 = r_max[2];
            end
            S_F: begin
                srt_d1 = r_c0;
                srt_d2 = r_c1;
                srt_d3 = r_c2;
            end
            default: begin
                srt_d1 = '0;
                srt_d2 = '0;
                srt_d3 = '0;
            end
        endcase
    end

    // Window latch and result capture, one cycle behind the op that produced it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NPIX); i++) begin
                r_p[i] <= '0;
            end
            for (int r = 0; r < int'(NROW); r++) begin
                r_max[r] <= '0;
                r_mid[r] <= '0;
                r_min[r] <= '0;
            end
            r_c0        <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_median    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < int'(NPIX); i++) begin
                    r_p[i] <= win_data[DW*i +: DW];
                end
            end
            case (r_state)
                S_R1: begin
                    r_max[0] <= srt_max;
                    r_mid[0] <= srt_mid;
                    r_min[0] <= srt_min;
                end
                S_R2: begin
                    r_max[1] <= srt_max;
                    r_mid[1] <= srt_mid;
                    r_min[1] <= srt_min;
                end
                S_W1: begin
                    r_max[2] <= srt_max;
                    r_mid[2] <= srt_mid;
                    r_min[2] <= srt_min;
                end
                S_C1: r_c0 <= srt_max;
                S_C2: r_c1 <= srt_mid;
                S_W2: r_c2 <= srt_min;
                S_W3: begin
                    r_median    <= srt_mid;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef MEDIAN_BORDER_BYPASS_EN
                S_BYP: begin
                    r_median    <= r_p[4];
                    r_out_valid <= 1'b1;
                end
`endif
                default: begin
                    r_out_valid <= r_out_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median3x3_sched.sv
// Directed bench for median3x3_sched with a registered sort3 model and a median scoreboard.
module tb_median3x3_sched;

    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [9*DW-1:0]   win_data;
    logic [DW-1:0]     srt_d1, srt_d2, srt_d3;
    logic [DW-1:0]     q_max, q_mid, q_min;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     median;
`ifdef MEDIAN_BORDER_BYPASS_EN
    logic              in_border;
`endif

    int                n_chk  = 0;
    int                n_pass = 0;
    logic [DW-1:0]     sb [$];

    always #5 clk = ~clk;

    median3x3_sched #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .srt_d1    (srt_d1),
        .srt_d2    (srt_d2),
        .srt_d3    (srt_d3),
        .srt_max   (q_max),
        .srt_mid   (q_mid),
        .srt_min   (q_min),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .median    (median)
`ifdef MEDIAN_BORDER_BYPASS_EN
        ,
        .in_border (in_border)
`endif
    );

    function automatic logic [3*DW-1:0] sort3(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] x0, x1, x2, t;
        x0 = a; x1 = b; x2 = c;
        if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
        if (x1 > x2) begin t = x1; x1 = x2; x2 = t; end
        if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
        return {x2, x1, x0};
    endfunction

    // Shared sorter model: registered, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {q_max, q_mid, q_min} <= '0;
        end else begin
            {q_max, q_mid, q_min} <= sort3(srt_d1, srt_d2, srt_d3);
        end
    end

    function automatic logic [DW-1:0] median9(input logic [9*DW-1:0] w);
        logic [DW-1:0] a [9];
        logic [DW-1:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[DW*i +: DW];
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin t = a[j]; a[j] = a[j-1]; a[j-1] = t; end
            end
        end
        return a[4];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9*DW-1:0] w, input logic [DW-1:0] exp_m);
        int n;
        n = 0;
        win_data = w;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(exp_m);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat, output logic [DW-1:0] exp_m);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        exp_m = (sb.size() != 0) ? sb.pop_front() : 'x;
        check({tag, "_median"}, 32'(median), 32'(exp_m));
    endtask

    task automatic run_window(input string tag, input logic [9*DW-1:0] w);
        int            lat;
        logic [DW-1:0] m;
        send(w, median9(w));
        wait_out(tag, lat, m);
        check({tag, "_latency"}, 32'(lat), 32'd10);
        step();
        check({tag, "_released"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [24:0]     exp_tr [10];
        logic [9*DW-1:0] w;
        logic [9*DW-1:0] wb;
        logic [DW-1:0]   m;
        int              lat;
        int              n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        win_data  = '0;
`ifdef MEDIAN_BORDER_BYPASS_EN
        in_border = 1'b0;
`endif
        #12;
        check("reset_outputs", 32'({out_valid, median, in_ready}), 32'({1'b0, 8'h00, 1'b1}));
        check("reset_srt_d", 32'({srt_d1, srt_d2, srt_d3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Test 1: 1..9, full operand trace then median
        exp_tr = '{{8'd1, 8'd2, 8'd3, 1'b0}, {8'd4, 8'd5, 8'd6, 1'b0}, {8'd7, 8'd8, 8'd9, 1'b0},
                   25'd0,
                   {8'd1, 8'd4, 8'd7, 1'b0}, {8'd2, 8'd5, 8'd8, 1'b0}, {8'd3, 8'd6, 8'd9, 1'b0},
                   25'd0,
                   {8'd7, 8'd5, 8'd3, 1'b0},
                   25'd0};
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(i + 1);
        send(w, 8'd5);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_trace_%0d", k), 32'({srt_d1, srt_d2, srt_d3, out_valid}), 32'(exp_tr[k]));
            step();
        end
        wait_out("t1", lat, m);
        check("t1_latency", 32'(lat), 32'd0);
        step();
        check("t1_released", 32'({out_valid, in_ready}), 32'b01);

        // Tests 2 and 3: uniform and alternating windows
        run_window("t2", {9{8'h7F}});
        run_window("t3", {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF});

        // Test 4a: downstream stall holds result and blocks new windows
        out_ready = 1'b0;
        w = {8'd10, 8'd200, 8'd30, 8'd40, 8'd90, 8'd60, 8'd70, 8'd80, 8'd50};
        send(w, median9(w));
        wait_out("t4_stall", lat, m);
        check("t4_stall_latency", 32'(lat), 32'd10);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("t4_hold_%0d", k), 32'({out_valid, median, in_ready}), 32'({1'b1, m, 1'b0}));
        end
        out_ready = 1'b1;
        step();
        check("t4_after_accept", 32'({out_valid, in_ready}), 32'b01);

        // Test 4b: back-to-back; second window offered while busy must wait
        w  = {8'd5, 8'd5, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd3, 8'd5};
        for (int i = 0; i < 9; i++) wb[DW*i +: DW] = DW'(8'hF0 - 8'(i * 16));
        send(w, median9(w));
        win_data = wb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            if (out_valid) begin
                m = (sb.size() != 0) ? sb.pop_front() : 'x;
                check("t4_b2b_first_median", 32'(median), 32'(m));
            end
            step();
            n++;
        end
        check("t4_busy_cycles", 32'(n), 32'd11);
        send(wb, median9(wb));
        wait_out("t4_b2b_second", lat, m);
        check("t4_b2b_second_latency", 32'(lat), 32'd10);
        step();

        // Test 5: asynchronous reset in C1 drops the window
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(9 - i);
        send(w, median9(w));
        for (int k = 0; k < 5; k++) step();
        check("t5_pre_reset_c1_ops", 32'({srt_d1, srt_d2, srt_d3}), 32'({8'd8, 8'd5, 8'd2}));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", 32'({out_valid, median, in_ready}), 32'({1'b0, 8'h00, 1'b1}));
        check("t5_reset_srt_d", 32'({srt_d1, srt_d2, srt_d3}), 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5_ready_after_release", 32'(in_ready), 32'd1);
        run_window("t5_next", {8'd33, 8'd11, 8'd99, 8'd22, 8'd77, 8'd44, 8'd66, 8'd55, 8'd88});

        // Random windows, small value range to force ties
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) begin
                w[DW*i +: DW] = (r < 2) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            end
            run_window($sformatf("rnd%0d", r), w);
        end

`ifdef MEDIAN_BORDER_BYPASS_EN
        // Test 6: border window returns the centre pixel without sorter ops
        w = {9{8'hFF}};
        w[DW*4 +: DW] = 8'h33;
        in_border = 1'b1;
        send(w, 8'h33);
        in_border = 1'b0;
        check("t6_srt_d_byp", 32'({srt_d1, srt_d2, srt_d3}), 32'd0);
        wait_out("t6", lat, m);
        check("t6_latency", 32'(lat), 32'd1);
        check("t6_srt_d_done", 32'({srt_d1, srt_d2, srt_d3}), 32'd0);
        step();
        check("t6_released", 32'({out_valid, in_ready}), 32'b01);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
